// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive unstuff/deserialize path.
//   rx_state_t           : receive FSM states
//   USB_SYNC_DECODED     : SYNC pattern after NRZI decode, LSB first
//   DEFAULT_STUFF_LEN    : ones run that forces a stuff bit
//   DEFAULT_SYNC_MIN_ZEROS : minimum zero run before the SYNC trailing 1
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        ERROR = 2'd2
    } rx_state_t;

    localparam logic [7:0]  USB_SYNC_DECODED       = 8'h80;
    localparam int unsigned DEFAULT_STUFF_LEN      = 6;
    localparam int unsigned DEFAULT_SYNC_MIN_ZEROS = 5;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned ZERO_CNT_W = 3;

endpackage

// File: rtl/rx_sync_detect.sv
// SYNC hunter: counts consecutive decoded zeros (saturating at 7) while
// enabled and flags a 1 that follows a long enough zero run.
//   clk, i_rst       : clock, synchronous active-high reset
//   i_enable         : hunting allowed (receiver idle); counter held clear otherwise
//   i_bit_valid      : i_bit is a new bit-time sample
//   i_bit            : decoded bit
//   i_eop            : end-of-packet pulse, restarts the hunt
//   o_sync_found_c   : combinational, this sample is the SYNC trailing 1
module rx_sync_detect
    import usb_rx_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = DEFAULT_SYNC_MIN_ZEROS
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_bit_valid,
    input  logic i_bit,
    input  logic i_eop,
    output logic o_sync_found_c
);

    localparam logic [ZERO_CNT_W-1:0] ZERO_SAT = '1;

    logic [ZERO_CNT_W-1:0] r_zero_cnt;

    // Zero-run counter; any 1, eop or leaving idle restarts the run.
    always_ff @(posedge clk) begin
        if (i_rst || !i_enable || i_eop) begin
            r_zero_cnt <= '0;
        end else if (i_bit_valid) begin
            if (i_bit) begin
                r_zero_cnt <= '0;
            end else if (r_zero_cnt != ZERO_SAT) begin
                r_zero_cnt <= ZERO_CNT_W'(r_zero_cnt + 1'b1);
            end
        end
    end

    // eop wins over a same-cycle bit.
    assign o_sync_found_c = i_enable && i_bit_valid && i_bit && !i_eop &&
                            (r_zero_cnt >= ZERO_CNT_W'(SYNC_MIN_ZEROS));

endmodule

// File: rtl/rx_unstuff_deserializer.sv
// USB receive stage after the NRZI decoder: SYNC hunt, bit unstuffing,
// stuff-violation detection and LSB-first byte packing.
//   clk, RST     : clock, synchronous active-high reset
//   bit_valid    : decoded_bit carries a new bit-time sample
//   decoded_bit  : NRZI-decoded bit
//   eop          : end-of-packet pulse from the line-state logic
//   rx_data      : last completed byte (held until the next one)
//   rx_valid     : one-cycle pulse, rx_data just updated
//   rx_active    : high from SYNC detection until eop or stuff error
//   stuff_err    : one-cycle pulse, a 1 sat where a stuff 0 was required
//   byte_err     : one-cycle pulse, eop arrived with a partial byte pending
module rx_unstuff_deserializer
    import usb_rx_pkg::*;
#(
    parameter int unsigned STUFF_LEN      = DEFAULT_STUFF_LEN,
    parameter int unsigned SYNC_MIN_ZEROS = DEFAULT_SYNC_MIN_ZEROS
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              bit_valid,
    input  logic              decoded_bit,
    input  logic              eop,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_active,
    output logic              stuff_err,
    output logic              byte_err
);

    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

    rx_state_t             r_state;
    rx_state_t             w_state_next;

    logic [ONES_W-1:0]     r_ones_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0]     r_shift;
    logic [BYTE_W-1:0]     r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_active;
    logic                  r_stuff_err;
    logic                  r_byte_err;

    logic [ONES_W-1:0]     w_ones_next;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_next;
    logic [BYTE_W-1:0]     w_shift_next;
    logic [BYTE_W-1:0]     w_rx_data_next;
    logic                  w_rx_valid_next;
    logic                  w_rx_active_next;
    logic                  w_stuff_err_next;
    logic                  w_byte_err_next;

    logic                  w_sync_found;
    logic                  w_is_stuff;
    logic [BYTE_W-1:0]     w_shifted;

    rx_sync_detect #(
        .SYNC_MIN_ZEROS (SYNC_MIN_ZEROS)
    ) u_sync_detect (
        .clk            (clk),
        .i_rst          (RST),
        .i_enable       (r_state == IDLE),
        .i_bit_valid    (bit_valid),
        .i_bit          (decoded_bit),
        .i_eop          (eop),
        .o_sync_found_c (w_sync_found)
    );

    // After STUFF_LEN ones the next sample is a stuff bit, not data.
    assign w_is_stuff = (r_ones_cnt == ONES_W'(STUFF_LEN));
    // LSB-first packing: newest bit enters at the MSB.
    assign w_shifted  = {decoded_bit, r_shift[BYTE_W-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_sync_found) begin
                    w_state_next = RECV;
                end
            end
            RECV: begin
                if (eop) begin
                    w_state_next = IDLE;
                end else if (bit_valid && w_is_stuff && decoded_bit) begin
                    w_state_next = ERROR;
                end
            end
            ERROR: begin
                if (eop) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and output decode; results are registered below.
    always_comb begin
        w_ones_next      = r_ones_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_valid_next  = 1'b0;
        w_rx_active_next = r_rx_active;
        w_stuff_err_next = 1'b0;
        w_byte_err_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_rx_active_next = 1'b0;
                if (w_sync_found) begin
                    // The SYNC trailing 1 counts toward the stuffing run.
                    w_ones_next      = ONES_W'(1);
                    w_bit_cnt_next   = '0;
                    w_shift_next     = '0;
                    w_rx_active_next = 1'b1;
                end
            end
            RECV: begin
                if (eop) begin
                    w_byte_err_next  = (r_bit_cnt != '0);
                    w_ones_next      = '0;
                    w_bit_cnt_next   = '0;
                    w_shift_next     = '0;
                    w_rx_active_next = 1'b0;
                end else if (bit_valid) begin
                    if (w_is_stuff) begin
                        w_ones_next = '0;
                        if (decoded_bit) begin
                            w_stuff_err_next = 1'b1;
                            w_rx_active_next = 1'b0;
                            w_bit_cnt_next   = '0;
                            w_shift_next     = '0;
                        end
                    end else begin
                        w_shift_next   = w_shifted;
                        w_bit_cnt_next = BIT_CNT_W'(r_bit_cnt + 1'b1);
                        w_ones_next    = decoded_bit ? ONES_W'(r_ones_cnt + 1'b1) : '0;
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            w_rx_data_next  = w_shifted;
                            w_rx_valid_next = 1'b1;
                        end
                    end
                end
            end
            ERROR: begin
                w_rx_active_next = 1'b0;
                w_ones_next      = '0;
                w_bit_cnt_next   = '0;
                w_shift_next     = '0;
            end
            default: begin
                w_rx_active_next = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_ones_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_active <= 1'b0;
            r_stuff_err <= 1'b0;
            r_byte_err  <= 1'b0;
        end else begin
            r_ones_cnt  <= w_ones_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_rx_active <= w_rx_active_next;
            r_stuff_err <= w_stuff_err_next;
            r_byte_err  <= w_byte_err_next;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_active = r_rx_active;
    assign stuff_err = r_stuff_err;
    assign byte_err  = r_byte_err;

endmodule

// File: tb/tb_rx_unstuff_deserializer.sv
// Directed bench for rx_unstuff_deserializer: drives decoded bit streams
// and checks bytes, stuffing, error pulses and rx_active framing.
module tb_rx_unstuff_deserializer;

    logic       clk;
    logic       RST;
    logic       bit_valid;
    logic       decoded_bit;
    logic       eop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       stuff_err;
    logic       byte_err;

    int n_cmp = 0;
    int n_err = 0;

    // Event counts gathered by the monitor.
    int n_valid   = 0;
    int n_stuff   = 0;
    int n_byte    = 0;
    int n_overlap = 0;
    int n_wide    = 0;
    logic prev_valid = 1'b0;
    logic prev_stuff = 1'b0;
    logic prev_byte  = 1'b0;

    rx_unstuff_deserializer dut (
        .clk         (clk),
        .RST         (RST),
        .bit_valid   (bit_valid),
        .decoded_bit (decoded_bit),
        .eop         (eop),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_active   (rx_active),
        .stuff_err   (stuff_err),
        .byte_err    (byte_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  n_valid = n_valid + 1;
        if (stuff_err) n_stuff = n_stuff + 1;
        if (byte_err)  n_byte  = n_byte + 1;
        if (stuff_err && byte_err) n_overlap = n_overlap + 1;
        if ((rx_valid && prev_valid) || (stuff_err && prev_stuff) || (byte_err && prev_byte))
            n_wide = n_wide + 1;
        prev_valid = rx_valid;
        prev_stuff = stuff_err;
        prev_byte  = byte_err;
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        bit_valid   = 1'b1;
        decoded_bit = b;
        eop         = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bit_valid   = 1'b0;
            decoded_bit = ~decoded_bit;
            eop         = 1'b0;
        end
    endtask

    task automatic send_bit_gap(input logic b, input int gap);
        send_bit(b);
        idle_cycles(gap);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_eop();
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        eop       = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1; bit_valid = 1'b0; decoded_bit = 1'b0; eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RST = 1'b0;
        n_cmp++;
        if ({rx_data, rx_valid, rx_active, stuff_err, byte_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {rx_data, rx_valid, rx_active, stuff_err, byte_err});
        end
    endtask

    task automatic test_basic_byte();
        int v0, s0, b0;
        v0 = n_valid; s0 = n_stuff; b0 = n_byte;
        idle_cycles(2);
        send_sync();
        n_cmp++;
        if (rx_active !== 1'b0) begin
            n_err++; $display("FAIL basic_active_pre: got %b expected 0", rx_active);
        end
        send_bit(1'b1);
        n_cmp++;
        if (rx_active !== 1'b1) begin
            n_err++; $display("FAIL basic_active_post_sync: got %b expected 1", rx_active);
        end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_eop();
        n_cmp++;
        if (rx_active !== 1'b1) begin
            n_err++; $display("FAIL basic_active_at_eop: got %b expected 1", rx_active);
        end
        idle_cycles(1);
        n_cmp++;
        if (rx_active !== 1'b0) begin
            n_err++; $display("FAIL basic_active_after_eop: got %b expected 0", rx_active);
        end
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'hA5 || (n_valid - v0) != 1) begin
            n_err++; $display("FAIL basic_byte: data %h valids %0d expected a5 and 1", rx_data, n_valid - v0);
        end
        n_cmp++;
        if ((n_stuff - s0) != 0 || (n_byte - b0) != 0) begin
            n_err++; $display("FAIL basic_no_err: stuff %0d byte %0d expected 0 0", n_stuff - s0, n_byte - b0);
        end
    endtask

    task automatic test_stuffing();
        int v0, s0;
        v0 = n_valid; s0 = n_stuff;
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'hFF || (n_valid - v0) != 1 || (n_stuff - s0) != 0) begin
            n_err++;
            $display("FAIL stuffing: data %h valids %0d stuff %0d expected ff 1 0",
                     rx_data, n_valid - v0, n_stuff - s0);
        end
    endtask

    task automatic test_stuff_violation();
        int v0, s0, b0;
        v0 = n_valid; s0 = n_stuff; b0 = n_byte;
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b1);
        idle_cycles(1);
        n_cmp++;
        if (rx_active !== 1'b0) begin
            n_err++; $display("FAIL violation_active: got %b expected 0", rx_active);
        end
        // Trailing bits that would look like SYNC+data are ignored in ERROR.
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_byte(8'h01);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if ((n_stuff - s0) != 1 || (n_valid - v0) != 0 || (n_byte - b0) != 0 || rx_data !== 8'hFF) begin
            n_err++;
            $display("FAIL violation: stuff %0d valids %0d byte %0d data %h expected 1 0 0 ff",
                     n_stuff - s0, n_valid - v0, n_byte - b0, rx_data);
        end
        v0 = n_valid;
        send_sync();
        send_byte(8'h5A);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'h5A || (n_valid - v0) != 1) begin
            n_err++; $display("FAIL violation_recover: data %h valids %0d expected 5a 1", rx_data, n_valid - v0);
        end
    endtask

    task automatic test_partial_byte();
        int v0, b0;
        v0 = n_valid; b0 = n_byte;
        send_sync();
        send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'h3C || (n_valid - v0) != 1 || (n_byte - b0) != 1) begin
            n_err++;
            $display("FAIL partial: data %h valids %0d byte_err %0d expected 3c 1 1",
                     rx_data, n_valid - v0, n_byte - b0);
        end
        v0 = n_valid;
        send_sync();
        send_byte(8'h81);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'h81 || (n_valid - v0) != 1 || (n_byte - b0) != 1) begin
            n_err++;
            $display("FAIL partial_next_sync: data %h valids %0d byte_err %0d expected 81 1 1",
                     rx_data, n_valid - v0, n_byte - b0);
        end
    endtask

    task automatic test_gaps_and_short_sync();
        int v0, b0;
        logic [7:0] pat;
        logic [7:0] by;
        pat = 8'h80;
        by  = 8'hA5;
        v0 = n_valid; b0 = n_byte;
        for (int i = 0; i < 8; i++) send_bit_gap(pat[i], i % 4);
        for (int i = 0; i < 8; i++) send_bit_gap(by[i], (i + 1) % 4);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'hA5 || (n_valid - v0) != 1 || (n_byte - b0) != 0) begin
            n_err++;
            $display("FAIL gaps: data %h valids %0d byte_err %0d expected a5 1 0",
                     rx_data, n_valid - v0, n_byte - b0);
        end
        // Four zeros are one short of an acceptable SYNC.
        v0 = n_valid;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        n_cmp++;
        if (rx_active !== 1'b0) begin
            n_err++; $display("FAIL short_sync: rx_active %b expected 0", rx_active);
        end
        idle_cycles(2);
        // Exactly five zeros is the shortest SYNC accepted.
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_byte(8'h0F);
        n_cmp++;
        if (rx_active !== 1'b1) begin
            n_err++; $display("FAIL min_sync_active: rx_active %b expected 1", rx_active);
        end
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'h0F || (n_valid - v0) != 1) begin
            n_err++; $display("FAIL min_sync: data %h valids %0d expected 0f 1", rx_data, n_valid - v0);
        end
    endtask

    task automatic test_reset_mid_packet();
        int v0, s0, b0;
        logic [7:0] junk;
        junk = 8'hCB;
        v0 = n_valid; s0 = n_stuff; b0 = n_byte;
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(posedge clk);
        #1;
        RST = 1'b1; bit_valid = 1'b0; eop = 1'b0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        n_cmp++;
        if ({rx_data, rx_valid, rx_active, stuff_err, byte_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h expected 000",
                     {rx_data, rx_valid, rx_active, stuff_err, byte_err});
        end
        // Without a fresh SYNC nothing is received.
        send_byte(junk);
        send_byte(8'hFF);
        n_cmp++;
        if (rx_active !== 1'b0) begin
            n_err++; $display("FAIL reset_needs_sync: rx_active %b expected 0", rx_active);
        end
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if ((n_valid - v0) != 0 || (n_stuff - s0) != 0 || (n_byte - b0) != 0) begin
            n_err++;
            $display("FAIL reset_no_pulses: valids %0d stuff %0d byte %0d expected 0 0 0",
                     n_valid - v0, n_stuff - s0, n_byte - b0);
        end
        send_sync();
        send_byte(8'hC3);
        do_eop();
        idle_cycles(3);
        n_cmp++;
        if (rx_data !== 8'hC3 || (n_valid - v0) != 1) begin
            n_err++; $display("FAIL reset_recover: data %h valids %0d expected c3 1", rx_data, n_valid - v0);
        end
    endtask

    task automatic test_pulse_shape();
        n_cmp++;
        if (n_overlap != 0 || n_wide != 0) begin
            n_err++; $display("FAIL pulse_shape: overlap %0d wide %0d expected 0 0", n_overlap, n_wide);
        end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_stuffing();
        test_stuff_violation();
        test_partial_byte();
        test_gaps_and_short_sync();
        test_reset_mid_packet();
        test_pulse_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_unstuff_deserializer.md
Name: rx_unstuff_deserializer

Overview:
Receive-path stage directly downstream of the NRZI decoder in the USB transceiver. It consumes the decoded bit stream, one bit per bit_valid strobe. It hunts for the SYNC field, removes stuffed bits, flags stuffing violations, and packs data bits LSB-first into bytes for the packet layer. The line-state logic supplies the eop signal, which terminates each packet.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit is a stuff bit that must be 0
SYNC_MIN_ZEROS, 5, minimum number of consecutive decoded 0s before a 1 that is accepted as end of SYNC (full SYNC is 0000_0001)

Ports:
clk  input  1  system clock
RST  input  1  reset, synchronous, active-high
bit_valid  input  1  strobe: decoded_bit is a new bit-time sample this cycle
decoded_bit  input  1  NRZI-decoded bit (1 = no transition)
eop  input  1  end-of-packet (SE0) detected, single-cycle pulse
rx_data  output  8  last completed byte; LSB is the first bit received
rx_valid  output  1  one-cycle pulse: rx_data holds a new byte
rx_active  output  1  high from SYNC detection until EOP or error
stuff_err  output  1  one-cycle pulse: a 1 arrived where a stuff 0 was required
byte_err  output  1  one-cycle pulse: EOP arrived with a partial byte pending

Behaviour:
- Reset (RST high at posedge): state IDLE; all counters and the shift register cleared; rx_data=8'h00; rx_valid, rx_active, stuff_err and byte_err all 0.
- All state advances only on cycles with bit_valid=1, except eop handling. decoded_bit is ignored when bit_valid=0.
- FSM states: IDLE, RECV, ERROR.
- IDLE:
  - zero_cnt counts consecutive 0s and saturates at 7.
  - Bit 1 with zero_cnt >= SYNC_MIN_ZEROS: go to RECV, rx_active<=1, ones_cnt<=1 (the SYNC trailing 1 counts toward stuffing), bit_cnt<=0.
  - Bit 1 otherwise: zero_cnt<=0.
  - eop: zero_cnt<=0.
- RECV, bit_valid=1:
  - If ones_cnt==STUFF_LEN, the bit is a stuff bit.
    - 0: dropped, ones_cnt<=0, bit_cnt unchanged.
    - 1: stuff_err pulse, rx_active<=0, shift register discarded, go to ERROR.
  - Otherwise the bit is a data bit.
    - Shift right, new bit into bit 7; bit_cnt<=bit_cnt+1 (3-bit, wraps).
    - ones_cnt<=bit ? ones_cnt+1 : 0.
    - On the 8th bit (bit_cnt==7): rx_data<=completed byte, and rx_valid pulses on the next cycle (latency 1 clk after the strobe carrying the 8th data bit).
- rx_data holds its value until the next completed byte; it is never cleared except by reset.
- RECV, eop:
  - eop has priority over a same-cycle bit_valid; that bit is discarded.
  - bit_cnt==0: clean end.
  - bit_cnt!=0: byte_err pulse and the partial byte is discarded.
  - In both cases rx_active<=0, counters cleared, go to IDLE.
- ERROR: all bits ignored; rx_active=0. eop returns to IDLE with no further error pulse.
- Output pulses are registered and are each exactly 1 cycle wide. stuff_err and byte_err are never asserted in the same cycle.
- rx_active deasserts in the cycle after eop or the error bit is sampled.
- RST asserted mid-packet aborts immediately to the reset state. No rx_valid or error pulse is produced for the aborted packet.

Decomposition:
- Package usb_rx_pkg holds:
  - rx_state_t enum {IDLE, RECV, ERROR}
  - localparams USB_SYNC_DECODED=8'h80, DEFAULT_STUFF_LEN=6, DEFAULT_SYNC_MIN_ZEROS=5
- One natural sub-module, rx_sync_detect: a zero-run counter plus compare that outputs sync_found.
- Unstuffing, shifting and the FSM stay in the top module.

Test Plan:
- Basic byte: SYNC 0,0,0,0,0,0,0,1 then 0xA5 LSB-first (1,0,1,0,0,1,0,1) then eop -> single rx_valid with rx_data=8'hA5; rx_active high from the cycle after the SYNC's 1 until the cycle after eop; no error pulses.
- Stuffing: SYNC, then eight data 1s with a stuff 0 inserted after the 5th data 1 (SYNC 1 + 5 = six ones), then eop -> rx_data=8'hFF, one rx_valid, no stuff_err.
- Stuff violation: same sequence but a 1 in the stuff position -> stuff_err pulse, rx_active falls, no rx_valid; later bits are ignored until eop; a subsequent valid packet decodes normally.
- Partial byte at EOP: SYNC, byte 8'h3C, then 3 data bits, then eop -> rx_valid for 8'h3C only, then a byte_err pulse; a second SYNC is accepted afterwards.
- Strobe gaps and short SYNC:
  - Basic-byte sequence with 0-3 idle cycles (bit_valid=0, decoded_bit toggling) between bits -> results identical to the basic-byte test.
  - 4 zeros then 1 -> rx_active stays 0.
- Reset mid-packet: RST pulse after SYNC plus 4 data bits -> all outputs 0 the next cycle, no rx_valid; the FSM needs a new SYNC before receiving again.
